mem_bus_scheduler: RTL and testbench

MEM_BUS_SCHEDULER -- requirements
Module: mem_bus_scheduler

---
 rtl/mem_bus_scheduler.sv | 228 ++++++++++++++++++++++
 tb/tb_mem_bus_scheduler.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_scheduler.sv
// Byte-serial memory bus scheduler: round-robin arbitration between instruction
// fetch, load and store ports onto a single 8-bit RAM with one-cycle read latency.
module mem_bus_scheduler #(
    parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    input  logic [1:0]  ld_width,
    input  logic        ld_signed,
    output logic        ld_done,
    output logic [31:0] ld_data,
    input  logic        st_req,
    input  logic [31:0] st_addr,
    input  logic [1:0]  st_width,
    input  logic [31:0] st_data,
    output logic        st_done
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [1:0] P_IF = 2'd0;
    localparam logic [1:0] P_LD = 2'd1;
    localparam logic [1:0] P_ST = 2'd2;

    state_t      state_q, state_d;
    logic [1:0]  port_q, port_d;
    logic [1:0]  last_q, last_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  nbytes_q, nbytes_d;
    logic [2:0]  cyc_q, cyc_d;
    logic        sgn_q, sgn_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;
    logic        if_done_q, if_done_d;
    logic        ld_done_q, ld_done_d;
    logic        st_done_q, st_done_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] ld_data_q, ld_data_d;

    logic [2:0]  elig;
    logic [1:0]  p1, p2, p3;
    logic        grant_v;
    logic [1:0]  grant_p;
    logic [2:0]  step;
    logic [2:0]  sidx;
    logic [31:0] ext;

    function automatic logic [2:0] width_bytes(input logic [1:0] w);
        case (w)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Priority rotates so the port after the last one granted is tried first.
    always_comb begin
        elig = {st_req && !(io_buffer_full && (st_addr >= IO_BASE)), ld_req, if_req};
        case (last_q)
            P_IF:    begin p1 = P_LD; p2 = P_ST; p3 = P_IF; end
            P_LD:    begin p1 = P_ST; p2 = P_IF; p3 = P_LD; end
            default: begin p1 = P_IF; p2 = P_LD; p3 = P_ST; end
        endcase
        grant_v = 1'b1;
        grant_p = p1;
        if (elig[p1])      grant_p = p1;
        else if (elig[p2]) grant_p = p2;
        else if (elig[p3]) grant_p = p3;
        else               grant_v = 1'b0;
    end

    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        last_d     = last_q;
        addr_d     = addr_q;
        nbytes_d   = nbytes_q;
        cyc_d      = cyc_q;
        sgn_d      = sgn_q;
        wdata_d    = wdata_q;
        rbuf_d     = rbuf_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        if_done_d  = if_done_q;
        ld_done_d  = ld_done_q;
        st_done_d  = st_done_q;
        if_data_d  = if_data_q;
        ld_data_d  = ld_data_q;
        step       = cyc_q + 3'd1;
        sidx       = step - 3'd2;
        ext        = '0;

        if (rdy_in) begin
            if_done_d = 1'b0;
            ld_done_d = 1'b0;
            st_done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_v) begin
                        port_d = grant_p;
                        last_d = grant_p;
                        cyc_d  = '0;
                        rbuf_d = '0;
                        case (grant_p)
                            P_IF: begin
                                addr_d = if_addr; nbytes_d = 3'd4; sgn_d = 1'b0; wdata_d = '0;
                            end
                            P_LD: begin
                                addr_d = ld_addr; nbytes_d = width_bytes(ld_width);
                                sgn_d = ld_signed; wdata_d = '0;
                            end
                            default: begin
                                addr_d = st_addr; nbytes_d = width_bytes(st_width);
                                sgn_d = 1'b0; wdata_d = st_data;
                            end
                        endcase
                        mem_a_d    = addr_d;
                        mem_wr_d   = (grant_p == P_ST);
                        mem_dout_d = (grant_p == P_ST) ? st_data[7:0] : 8'h00;
                        state_d    = (grant_p == P_ST) ? WRITE : READ;
                    end
                end
                READ: begin
                    cyc_d   = step;
                    mem_a_d = (step < nbytes_q) ? addr_q + {29'd0, step} : '0;
                    // RAM data lags its address by two edges.
                    if (step >= 3'd2) rbuf_d[{sidx[1:0], 3'b000} +: 8] = mem_din;
                    case (nbytes_q)
                        3'd1:    ext = {{24{sgn_q & rbuf_d[7]}}, rbuf_d[7:0]};
                        3'd2:    ext = {{16{sgn_q & rbuf_d[15]}}, rbuf_d[15:0]};
                        default: ext = rbuf_d;
                    endcase
                    if (step == nbytes_q + 3'd1) begin
                        state_d = DONE;
                        if (port_q == P_IF) begin
                            if_done_d = 1'b1;
                            if_data_d = rbuf_d;
                        end else begin
                            ld_done_d = 1'b1;
                            ld_data_d = ext;
                        end
                    end
                end
                WRITE: begin
                    cyc_d = step;
                    if (step < nbytes_q) begin
                        mem_a_d    = addr_q + {29'd0, step};
                        mem_dout_d = wdata_q[{step[1:0], 3'b000} +: 8];
                        mem_wr_d   = 1'b1;
                    end else begin
                        mem_a_d    = '0;
                        mem_dout_d = '0;
                        mem_wr_d   = 1'b0;
                        st_done_d  = 1'b1;
                        state_d    = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            port_q     <= P_IF;
            last_q     <= P_ST;
            addr_q     <= '0;
            nbytes_q   <= '0;
            cyc_q      <= '0;
            sgn_q      <= 1'b0;
            wdata_q    <= '0;
            rbuf_q     <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
            if_done_q  <= 1'b0;
            ld_done_q  <= 1'b0;
            st_done_q  <= 1'b0;
            if_data_q  <= '0;
            ld_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            port_q     <= port_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            nbytes_q   <= nbytes_d;
            cyc_q      <= cyc_d;
            sgn_q      <= sgn_d;
            wdata_q    <= wdata_d;
            rbuf_q     <= rbuf_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            if_done_q  <= if_done_d;
            ld_done_q  <= ld_done_d;
            st_done_q  <= st_done_d;
            if_data_q  <= if_data_d;
            ld_data_q  <= ld_data_d;
        end
    end

    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    assign mem_wr   = mem_wr_q;
    assign if_done  = if_done_q;
    assign ld_done  = ld_done_q;
    assign st_done  = st_done_q;
    assign if_data  = if_data_q;
    assign ld_data  = ld_data_q;

endmodule

// File: tb/tb_mem_bus_scheduler.sv
// Bench for mem_bus_scheduler: byte RAM environment plus a flat-array memory
// reference that predicts load/fetch results and store effects.
module tb_mem_bus_scheduler;

    localparam logic [31:0] IO_BASE = 32'h0003_0000;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done;
    logic [31:0] if_data;
    logic        ld_req = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [1:0]  ld_width = '0;
    logic        ld_signed = 1'b0;
    logic        ld_done;
    logic [31:0] ld_data;
    logic        st_req = 1'b0;
    logic [31:0] st_addr = '0;
    logic [1:0]  st_width = '0;
    logic [31:0] st_data = '0;
    logic        st_done;

    int checks = 0;
    int failures = 0;

    logic [7:0]  ram [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];
    logic [39:0] wlog [$];

    always #5 clk_in = ~clk_in;

    mem_bus_scheduler #(.IO_BASE(IO_BASE)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_width(ld_width), .ld_signed(ld_signed),
        .ld_done(ld_done), .ld_data(ld_data),
        .st_req(st_req), .st_addr(st_addr), .st_width(st_width), .st_data(st_data),
        .st_done(st_done)
    );

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    // RAM shares the global ready with the scheduler.
    always @(posedge clk_in) begin
        if (rdy_in) begin
            if (mem_wr) begin
                ram[mem_a] = mem_dout;
                wlog.push_back({mem_a, mem_dout});
            end
            mem_din <= ram_rd(mem_a);
        end
    end

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic int unsigned nbytes_of(input logic [1:0] w);
        return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input int unsigned n, input logic sgn);
        logic [31:0] v;
        v = '0;
        for (int unsigned i = 0; i < n; i++) v = v | ({24'd0, ref_byte(a + i)} << (8 * i));
        if (n < 4 && sgn && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input int unsigned n, input logic [31:0] d);
        for (int unsigned i = 0; i < n; i++) ref_mem[a + i] = d[8 * i +: 8];
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] b);
        ram[a] = b;
        ref_mem[a] = b;
    endtask

    function automatic logic done_of(input int p);
        case (p)
            0:       return if_done;
            1:       return ld_done;
            default: return st_done;
        endcase
    endfunction

    task automatic run_txn(input int p, input logic [31:0] addr, input logic [1:0] w, input logic sgn,
                           input logic [31:0] data, output logic [31:0] got, output int cyc);
        case (p)
            0:       begin if_addr = addr; if_req = 1'b1; end
            1:       begin ld_addr = addr; ld_width = w; ld_signed = sgn; ld_req = 1'b1; end
            default: begin st_addr = addr; st_width = w; st_data = data; st_req = 1'b1; end
        endcase
        cyc = 0;
        do begin
            @(negedge clk_in);
            cyc++;
        end while (!done_of(p) && cyc < 60);
        got = (p == 1) ? ld_data : if_data;
        if_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
        checks++;
        if (done_of(p) !== 1'b1) begin
            failures++;
            $display("FAIL txn_timeout port=%0d got no done within %0d cycles, required done", p, cyc);
        end
        @(negedge clk_in);
        checks++;
        if (done_of(p) !== 1'b0) begin
            failures++;
            $display("FAIL done_one_cycle port=%0d got done=%b, required 0", p, done_of(p));
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        checks++;
        if ({mem_a, mem_dout, mem_wr} !== 41'd0) begin
            failures++;
            $display("FAIL reset_bus got a=%h d=%h wr=%b, required 0", mem_a, mem_dout, mem_wr);
        end
        checks++;
        if ({if_done, ld_done, st_done} !== 3'b000) begin
            failures++;
            $display("FAIL reset_done got %b, required 000", {if_done, ld_done, st_done});
        end
        checks++;
        if ({if_data, ld_data} !== 64'd0) begin
            failures++;
            $display("FAIL reset_data got if=%h ld=%h, required 0", if_data, ld_data);
        end
        rst_in = 1'b1;
    endtask

    task automatic test_word_load();
        logic [31:0] exp_a [6];
        exp_a = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h0, 32'h0};
        poke(32'h100, 8'h78); poke(32'h101, 8'h56); poke(32'h102, 8'h34); poke(32'h103, 8'h12);
        ld_addr = 32'h100; ld_width = 2'd2; ld_signed = 1'b0; ld_req = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk_in);
            checks++;
            if (mem_a !== exp_a[c - 1] || mem_wr !== 1'b0) begin
                failures++;
                $display("FAIL word_load_addr cycle=%0d got a=%h wr=%b, required a=%h wr=0", c, mem_a, mem_wr, exp_a[c - 1]);
            end
            checks++;
            if (ld_done !== (c == 6)) begin
                failures++;
                $display("FAIL word_load_done cycle=%0d got %b, required %b", c, ld_done, c == 6);
            end
        end
        ld_req = 1'b0;
        checks++;
        if (ld_data !== 32'h1234_5678) begin
            failures++;
            $display("FAIL word_load_data got %h, required 12345678", ld_data);
        end
        @(negedge clk_in);
        checks++;
        if (ld_done !== 1'b0 || ld_data !== 32'h1234_5678) begin
            failures++;
            $display("FAIL word_load_hold got done=%b data=%h, required 0 12345678", ld_done, ld_data);
        end
    endtask

    task automatic test_signed_byte();
        logic [31:0] got;
        int cyc;
        poke(32'h200, 8'h80);
        run_txn(1, 32'h200, 2'd0, 1'b1, '0, got, cyc);
        checks++;
        if (got !== 32'hFFFF_FF80 || cyc != 3) begin
            failures++;
            $display("FAIL signed_byte got %h lat=%0d, required ffffff80 lat=3", got, cyc);
        end
        run_txn(1, 32'h200, 2'd0, 1'b0, '0, got, cyc);
        checks++;
        if (got !== 32'h0000_0080) begin
            failures++;
            $display("FAIL unsigned_byte got %h, required 00000080", got);
        end
    endtask

    task automatic test_half_store();
        logic [31:0] got;
        int cyc;
        poke(32'h302, 8'h5A);
        wlog.delete();
        run_txn(2, 32'h300, 2'd1, 1'b0, 32'hAABB_CCDD, got, cyc);
        ref_store(32'h300, 2, 32'hAABB_CCDD);
        checks++;
        if (wlog.size() != 2 || wlog[0] !== {32'h300, 8'hDD} || wlog[1] !== {32'h301, 8'hCC}) begin
            failures++;
            $display("FAIL half_store_writes got n=%0d first=%h, required 2 writes 300:dd 301:cc",
                     wlog.size(), (wlog.size() > 0) ? wlog[0] : 40'd0);
        end
        checks++;
        if (ram_rd(32'h302) !== 8'h5A || cyc != 3) begin
            failures++;
            $display("FAIL half_store_bound got ram302=%h lat=%0d, required 5a lat=3", ram_rd(32'h302), cyc);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] got;
        int cyc;
        poke(32'hFFFF_FFFE, 8'hA1); poke(32'hFFFF_FFFF, 8'hB2); poke(32'h0, 8'hC3); poke(32'h1, 8'hD4);
        run_txn(0, 32'hFFFF_FFFE, 2'd2, 1'b0, '0, got, cyc);
        checks++;
        if (got !== ref_load(32'hFFFF_FFFE, 4, 1'b0) || cyc != 6) begin
            failures++;
            $display("FAIL wrap_fetch got %h lat=%0d, required %h lat=6", got, cyc, ref_load(32'hFFFF_FFFE, 4, 1'b0));
        end
    endtask

    task automatic test_random();
        logic [31:0] got, addr, data, expv;
        logic [1:0]  w;
        logic        sgn;
        int          p, cyc, bad;
        int unsigned n;
        for (int unsigned a = 32'h1000; a < 32'h1048; a++) poke(a, 8'($urandom));
        for (int t = 0; t < 40; t++) begin
            p = int'($urandom_range(0, 2));
            addr = 32'h1000 + $urandom_range(0, 63);
            w = (p == 0) ? 2'd2 : 2'($urandom_range(0, 3));
            sgn = 1'($urandom);
            data = $urandom;
            io_buffer_full = 1'($urandom);
            n = nbytes_of(w);
            expv = (p == 0) ? ref_load(addr, 4, 1'b0) : ref_load(addr, n, sgn);
            run_txn(p, addr, w, sgn, data, got, cyc);
            checks++;
            if (cyc != int'(n) + ((p == 2) ? 1 : 2)) begin
                failures++;
                $display("FAIL rand_latency t=%0d port=%0d got %0d, required %0d", t, p, cyc, int'(n) + ((p == 2) ? 1 : 2));
            end
            if (p == 2) ref_store(addr, n, data);
            else begin
                checks++;
                if (got !== expv) begin
                    failures++;
                    $display("FAIL rand_load t=%0d port=%0d addr=%h w=%0d s=%b got %h, required %h", t, p, addr, w, sgn, got, expv);
                end
            end
        end
        io_buffer_full = 1'b0;
        bad = 0;
        for (int unsigned a = 32'h1000; a < 32'h1048; a++) if (ram_rd(a) !== ref_byte(a)) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rand_ram_image got %0d differing bytes, required 0", bad);
        end
    endtask

    task automatic test_contention();
        int order [$];
        int cyc, sum;
        poke(32'h1100, 8'h11); poke(32'h1101, 8'h22); poke(32'h1102, 8'h33); poke(32'h1103, 8'h44);
        rst_in = 1'b0;
        if_addr = 32'h1104; if_req = 1'b1;
        ld_addr = 32'h1100; ld_width = 2'd2; ld_signed = 1'b0; ld_req = 1'b1;
        st_addr = 32'h1200; st_width = 2'd0; st_data = 32'h0000_00C3; st_req = 1'b1;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        cyc = 0;
        while (order.size() < 6 && cyc < 200) begin
            @(negedge clk_in);
            cyc++;
            sum = int'(if_done) + int'(ld_done) + int'(st_done);
            if (sum != 0) begin
                checks++;
                if (sum != 1) begin
                    failures++;
                    $display("FAIL contention_single got %0d dones together, required 1", sum);
                end
                order.push_back(if_done ? 0 : ld_done ? 1 : 2);
                if (ld_done) begin
                    checks++;
                    if (ld_data !== 32'h4433_2211) begin
                        failures++;
                        $display("FAIL contention_ld_data got %h, required 44332211", ld_data);
                    end
                end
            end
        end
        if_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
        ref_store(32'h1200, 1, 32'h0000_00C3);
        checks++;
        if (order.size() != 6) begin
            failures++;
            $display("FAIL contention_timeout got %0d completions, required 6", order.size());
        end
        for (int i = 0; i < order.size(); i++) begin
            checks++;
            if (order[i] != i % 3) begin
                failures++;
                $display("FAIL contention_order idx=%0d got port %0d, required %0d", i, order[i], i % 3);
            end
        end
        repeat (2) @(negedge clk_in);
    endtask

    task automatic test_io_stall();
        logic [31:0] got;
        int cyc, st_seen, if_seen;
        wlog.delete();
        io_buffer_full = 1'b1;
        st_addr = IO_BASE; st_width = 2'd0; st_data = 32'h0000_005E; st_req = 1'b1;
        if_addr = 32'h1000; if_req = 1'b1;
        st_seen = 0; if_seen = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk_in);
            if (st_done) st_seen++;
            if (if_done) begin if_seen++; if_req = 1'b0; end
        end
        checks++;
        if (if_seen != 1 || st_seen != 0 || wlog.size() != 0) begin
            failures++;
            $display("FAIL io_stall got if=%0d st=%0d writes=%0d, required 1 0 0", if_seen, st_seen, wlog.size());
        end
        io_buffer_full = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk_in);
            cyc++;
        end while (!st_done && cyc < 30);
        st_req = 1'b0;
        checks++;
        if (st_done !== 1'b1 || cyc != 2) begin
            failures++;
            $display("FAIL io_release got done=%b lat=%0d, required 1 lat=2", st_done, cyc);
        end
        checks++;
        if (wlog.size() != 1 || wlog[0] !== {IO_BASE, 8'h5E}) begin
            failures++;
            $display("FAIL io_write got n=%0d, required one write 30000:5e", wlog.size());
        end
        @(negedge clk_in);
        io_buffer_full = 1'b1;
        run_txn(2, IO_BASE - 32'd1, 2'd0, 1'b0, 32'h0000_0077, got, cyc);
        io_buffer_full = 1'b0;
        checks++;
        if (cyc != 2 || ram_rd(IO_BASE - 32'd1) !== 8'h77) begin
            failures++;
            $display("FAIL below_io_store got lat=%0d byte=%h, required lat=2 77", cyc, ram_rd(IO_BASE - 32'd1));
        end
    endtask

    task automatic test_pause();
        logic [31:0] snap;
        int cyc;
        ld_addr = 32'h100; ld_width = 2'd3; ld_signed = 1'b1; ld_req = 1'b1;
        cyc = 0;
        snap = '0;
        do begin
            @(negedge clk_in);
            cyc++;
            if (cyc == 2) begin snap = mem_a; rdy_in = 1'b0; end
            else if (cyc >= 3 && cyc <= 5) begin
                checks++;
                if (mem_a !== snap || mem_wr !== 1'b0 || ld_done !== 1'b0) begin
                    failures++;
                    $display("FAIL pause_freeze cycle=%0d got a=%h done=%b, required a=%h done=0", cyc, mem_a, ld_done, snap);
                end
                if (cyc == 5) rdy_in = 1'b1;
            end
        end while (!ld_done && cyc < 40);
        ld_req = 1'b0;
        checks++;
        if (ld_data !== 32'h1234_5678 || cyc != 9 || snap !== 32'h101) begin
            failures++;
            $display("FAIL pause_result got data=%h lat=%0d snap=%h, required 12345678 lat=9 snap=101", ld_data, cyc, snap);
        end
        @(negedge clk_in);
    endtask

    task automatic test_reset_mid_store();
        int wsz;
        wlog.delete();
        st_addr = 32'h1300; st_width = 2'd2; st_data = 32'h1122_3344; st_req = 1'b1;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        st_req = 1'b0;
        checks++;
        if (mem_wr !== 1'b0 || mem_a !== 32'h0 || st_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort got wr=%b a=%h done=%b, required 0 0 0", mem_wr, mem_a, st_done);
        end
        wsz = wlog.size();
        checks++;
        if (wsz != 2 || wlog[0] !== {32'h1300, 8'h44}) begin
            failures++;
            $display("FAIL reset_partial got %0d writes, required 2 starting 1300:44", wsz);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_in);
            checks++;
            if (mem_wr !== 1'b0 || st_done !== 1'b0) begin
                failures++;
                $display("FAIL reset_quiet cycle=%0d got wr=%b done=%b, required 0 0", c, mem_wr, st_done);
            end
        end
        checks++;
        if (wlog.size() != wsz) begin
            failures++;
            $display("FAIL reset_no_write got %0d writes, required %0d", wlog.size(), wsz);
        end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_signed_byte();
        test_half_store();
        test_wrap();
        test_random();
        test_contention();
        test_io_stall();
        test_pause();
        test_reset_mid_store();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
